// File: rtl/rpi_bus_pkg.sv
// Shared definitions for the RPI parallel bus transmit/receive paths.
// RPI_TX_CHECKSUM_EN widens FIFO entries to carry the frame-last flag.
package rpi_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        WAIT_LOW  = 2'd2
    } tx_state_e;

    localparam int         SYNC_STAGES   = 2;
    localparam logic [7:0] FILL_BYTE_DEF = 8'h00;

    // Level of bus_rnw for each transfer direction, as seen by the FPGA.
    localparam logic BUS_DIR_WRITE = 1'b0;
    localparam logic BUS_DIR_READ  = 1'b1;

`ifdef RPI_TX_CHECKSUM_EN
    localparam int TX_ENTRY_W = 9;
`else
    localparam int TX_ENTRY_W = 8;
`endif

endpackage

// File: rtl/rpi_tx_fifo.sv
// Synchronous FIFO with a registered head peek; the peek shows FILL while empty.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module rpi_tx_fifo #(
    parameter int             WIDTH = 8,
    parameter int             DEPTH = 16,
    parameter logic [WIDTH-1:0] FILL  = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= FILL;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            head <= empty ? FILL : mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/rpi_bus_tx.sv
// FPGA-to-RPI read-direction transmitter: streams FIFO bytes onto bus_data per bus_clk.
// RPI_TX_CHECKSUM_EN appends a mod-256 sum byte after each frame's last byte.
module rpi_bus_tx
    import rpi_bus_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] FILL_BYTE  = FILL_BYTE_DEF
) (
    input  logic                          clk_100mhz,
    input  logic                          reset_n,
    input  logic                          bus_clk,
    input  logic                          bus_rnw,
    inout  wire  [7:0]                    bus_data,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          underflow,
    input  logic                          underflow_clr
);
    tx_state_e               state;
    tx_state_e               state_nxt;
    logic [SYNC_STAGES-1:0]  rnw_sh;
    logic [SYNC_STAGES:0]    clk_sh;
    logic                    rnw_sync;
    logic                    clk_sync;
    logic                    clk_fall;
    logic                    consume;
    logic                    drive_en;
    logic                    out_ready;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    underflow_set;
    logic [TX_ENTRY_W-1:0]   head;
    logic [TX_ENTRY_W-1:0]   wr_entry;
    logic [7:0]              bus_data_out;

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            rnw_sh    <= '0;
            clk_sh    <= '0;
            state     <= IDLE;
            out_ready <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rnw_sh    <= {rnw_sh[SYNC_STAGES-2:0], bus_rnw};
            clk_sh    <= {clk_sh[SYNC_STAGES-1:0], bus_clk};
            state     <= state_nxt;
            out_ready <= 1'b1;
            if (underflow_set)      underflow <= 1'b1;
            else if (underflow_clr) underflow <= 1'b0;
        end
    end

    assign rnw_sync = rnw_sh[SYNC_STAGES-1];
    assign clk_sync = clk_sh[SYNC_STAGES-1];
    assign clk_fall = clk_sh[SYNC_STAGES] && !clk_sync;

    always_comb begin
        state_nxt = state;
        consume   = 1'b0;
        case (state)
            IDLE:      if (rnw_sync == BUS_DIR_READ) state_nxt = WAIT_HIGH;
            WAIT_HIGH: if (clk_sync) state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (clk_fall) begin
                    consume   = 1'b1;
                    state_nxt = WAIT_HIGH;
                end
            end
            default:   state_nxt = IDLE;
        endcase
        // Dropping rnw abandons the presented byte so it is re-sent next burst.
        if (rnw_sync != BUS_DIR_READ) begin
            state_nxt = IDLE;
            consume   = 1'b0;
        end
    end

    assign drive_en = (state != IDLE);
    assign bus_data = drive_en ? bus_data_out : 8'hzz;
    assign s_ready  = out_ready && !fifo_full;

`ifdef RPI_TX_CHECKSUM_EN
    logic       csum_pending;
    logic [7:0] csum;

    assign wr_entry      = {s_last, s_data};
    assign pop           = consume && !fifo_empty && !csum_pending;
    assign underflow_set = consume && fifo_empty && !csum_pending;
    assign bus_data_out  = csum_pending ? csum : head[7:0];

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            csum_pending <= 1'b0;
            csum         <= '0;
        end else if (consume && csum_pending) begin
            csum_pending <= 1'b0;
            csum         <= '0;
        end else if (pop) begin
            csum <= csum + head[7:0];
            if (head[8]) csum_pending <= 1'b1;
        end
    end
`else
    logic unused_last;

    assign unused_last   = s_last;
    assign wr_entry      = s_data;
    assign pop           = consume && !fifo_empty;
    assign underflow_set = consume && fifo_empty;
    assign bus_data_out  = head;
`endif

    rpi_tx_fifo #(
        .WIDTH (TX_ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .FILL  (TX_ENTRY_W'(FILL_BYTE))
    ) u_fifo (
        .clk     (clk_100mhz),
        .rst_n   (reset_n),
        .push    (s_valid && s_ready),
        .wr_data (wr_entry),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule
